// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux_7 scan sequencer.
//   SEL_W  : mux select width
//   N_CH   : channel count (2**SEL_W)
//   BYTE_W : packed output word width
//   CNT_W  : width of the channel counter (holds 0..N_CH)
//   scan_state_t   : sequencer state encoding
//   decode_num_ch  : maps the num_ch encoding 0 -> N_CH
package mux_pkg;

    localparam int unsigned SEL_W  = 7;
    localparam int unsigned N_CH   = 2 ** SEL_W;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = SEL_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FLUSH,
        ST_DONE
    } scan_state_t;

    // A programmed count of 0 requests a full sweep of all channels.
    function automatic logic [CNT_W-1:0] decode_num_ch(input logic [CNT_W-1:0] n);
        return (n == '0) ? CNT_W'(N_CH) : n;
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Byte stream carrying packed mux samples out of the sequencer.
//   data       : packed byte
//   data_valid : byte available
//   data_ready : consumer accepts the byte
// master = producer (sequencer), slave = consumer.
interface mux_scan_ctrl_if #(
    parameter int unsigned BYTE_W = mux_pkg::BYTE_W
) ();

    logic [BYTE_W-1:0] data;
    logic              data_valid;
    logic              data_ready;

    modport master (output data, output data_valid, input data_ready);
    modport slave  (input data, input data_valid, output data_ready);

endinterface

// File: rtl/mux_scan_ctrl_bit_packer.sv
// Packs one sampled bit per step LSB-first into bytes and holds the
// result in a one-entry valid/ready output register.
//   clk, rst_n  : clock, synchronous active-low reset
//   clear       : restart assembly at bit 0 (scan launch)
//   sample_en   : take sample_bit this edge
//   sample_bit  : sampled mux output
//   last        : this sample is the final one of the scan
//   data_ready  : consumer accepts the byte
//   data        : output byte register
//   data_valid  : output byte available
//   stall       : output register full and not draining
module bit_packer
    import mux_pkg::*;
#(
    parameter int unsigned BYTE_W = mux_pkg::BYTE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              sample_en,
    input  logic              sample_bit,
    input  logic              last,
    input  logic              data_ready,
    output logic [BYTE_W-1:0] data,
    output logic              data_valid,
    output logic              stall
);

    localparam int unsigned IDX_W = $clog2(BYTE_W);

    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [BYTE_W-1:0] byte_w;

    assign stall      = valid_q && !data_ready;
    assign data       = data_q;
    assign data_valid = valid_q;

    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        byte_w  = shreg_q;

        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        if (clear) begin
            shreg_d = '0;
            idx_d   = '0;
        end else if (sample_en) begin
            byte_w[idx_q] = sample_bit;
            if ((idx_q == IDX_W'(BYTE_W - 1)) || last) begin
                // Shift register restarts empty so a partial final byte
                // carries zeros in its unsampled upper bits.
                data_d  = byte_w;
                valid_d = 1'b1;
                shreg_d = '0;
                idx_d   = '0;
            end else begin
                shreg_d = byte_w;
                idx_d   = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequencer for the 128:1 mux_7 selector: walks a window of channels one
// per cycle, samples the mux output and streams the bits out as bytes.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : launch a scan (taken in IDLE only)
//   first_ch   : first channel, captured on accepted start
//   num_ch     : channel count 1..128 (0 = 128), captured on accepted start
//   ctrl       : registered mux select
//   mux_out    : mux output for the channel on ctrl
//   out_if     : byte stream (master side)
//   busy       : high during SCAN and FLUSH
//   done       : one-cycle completion pulse
module mux_scan_ctrl
    import mux_pkg::*;
#(
    parameter int unsigned SEL_W  = mux_pkg::SEL_W,
    parameter int unsigned BYTE_W = mux_pkg::BYTE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SEL_W-1:0] first_ch,
    input  logic [SEL_W:0]   num_ch,
    output logic [SEL_W-1:0] ctrl,
    input  logic             mux_out,
    mux_scan_ctrl_if.master  out_if,
    output logic             busy,
    output logic             done
);

    scan_state_t      state_q, state_d;
    logic [SEL_W-1:0] ctrl_q, ctrl_d;
    logic [SEL_W:0]   remain_q, remain_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic step;
    logic clear;
    logic last;
    logic stall;

    assign ctrl = ctrl_q;
    assign busy = busy_q;
    assign done = done_q;
    assign last = (remain_q == {{SEL_W{1'b0}}, 1'b1});

    bit_packer #(
        .BYTE_W (BYTE_W)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .sample_en  (step),
        .sample_bit (mux_out),
        .last       (last),
        .data_ready (out_if.data_ready),
        .data       (out_if.data),
        .data_valid (out_if.data_valid),
        .stall      (stall)
    );

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        remain_d = remain_q;
        step     = 1'b0;
        clear    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SCAN;
                    ctrl_d   = first_ch;
                    remain_d = decode_num_ch(num_ch);
                    clear    = 1'b1;
                end
            end
            ST_SCAN: begin
                // mux_out reflects the channel ctrl has shown for a full cycle.
                if (!stall) begin
                    step     = 1'b1;
                    ctrl_d   = ctrl_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    if (last) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (out_if.data_valid && out_if.data_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SCAN) || (state_d == ST_FLUSH);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            remain_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            remain_q <= remain_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [6:0]   first_ch;
    logic [7:0]   num_ch;
    logic [6:0]   ctrl;
    logic         mux_out;
    logic         busy;
    logic         done;
    logic [127:0] in_vec;

    int checks;
    int errors;

    mux_scan_ctrl_if #(.BYTE_W(8)) s_if ();

    // Behavioural stand-in for mux_7: combinational select of in_vec.
    assign mux_out = in_vec[ctrl];

    mux_scan_ctrl #(
        .SEL_W  (7),
        .BYTE_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .first_ch (first_ch),
        .num_ch   (num_ch),
        .ctrl     (ctrl),
        .mux_out  (mux_out),
        .out_if   (s_if),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_scan(input logic [6:0] f, input logic [7:0] n);
        first_ch = f;
        num_ch   = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        logic [6:0] ce;
        int         nbytes;
        int         done_edge;

        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        first_ch = '0;
        num_ch = '0;
        in_vec = '0;
        s_if.data_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_ctrl",  32'(ctrl), 32'd0);
        check("rst_data",  32'(s_if.data), 32'd0);
        check("rst_valid", 32'(s_if.data_valid), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: basic byte, in7..in0 = 1010_0110
        in_vec = '0;
        in_vec[7:0] = 8'hA6;
        start_scan(7'd0, 8'd8);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ctrl_first", 32'(ctrl), 32'd0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("t1_ctrl", 32'(ctrl), 32'(k));
            check("t1_novalid", 32'(s_if.data_valid), 32'd0);
        end
        tick();
        check("t1_valid", 32'(s_if.data_valid), 32'd1);
        check("t1_data",  32'(s_if.data), 32'hA6);
        check("t1_busy_flush", 32'(busy), 32'd1);
        tick();
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy_done", 32'(busy), 32'd0);
        check("t1_valid_clr", 32'(s_if.data_valid), 32'd0);
        tick();
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_ctrl_hold", 32'(ctrl), 32'd8);

        // 2: wrap-around 124..3
        in_vec = '0;
        in_vec[127:124] = 4'hF;
        start_scan(7'd124, 8'd8);
        for (int k = 0; k < 8; k++) begin
            ce = 7'(124 + k);
            check("t2_ctrl", 32'(ctrl), 32'(ce));
            tick();
        end
        check("t2_valid", 32'(s_if.data_valid), 32'd1);
        check("t2_data",  32'(s_if.data), 32'h0F);
        wait_done("t2_done", 4);
        tick();

        // 3: partial byte, neighbours above the window set high
        in_vec = '0;
        in_vec[10] = 1'b1;
        in_vec[12] = 1'b1;
        in_vec[17:13] = '1;
        start_scan(7'd10, 8'd3);
        tick();
        tick();
        check("t3_novalid", 32'(s_if.data_valid), 32'd0);
        tick();
        check("t3_valid", 32'(s_if.data_valid), 32'd1);
        check("t3_data",  32'(s_if.data), 32'h05);
        check("t3_busy",  32'(busy), 32'd1);
        tick();
        check("t3_done", 32'(done), 32'd1);
        tick();

        // 4: backpressure after the first byte
        in_vec = '0;
        in_vec[39:32] = 8'h3C;
        in_vec[47:40] = 8'hC5;
        start_scan(7'd32, 8'd16);
        repeat (8) tick();
        check("t4_valid1", 32'(s_if.data_valid), 32'd1);
        check("t4_data1",  32'(s_if.data), 32'h3C);
        check("t4_ctrl8",  32'(ctrl), 32'd40);
        s_if.data_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_stall_ctrl",  32'(ctrl), 32'd40);
            check("t4_stall_data",  32'(s_if.data), 32'h3C);
            check("t4_stall_valid", 32'(s_if.data_valid), 32'd1);
        end
        s_if.data_ready = 1'b1;
        repeat (7) tick();
        check("t4_gap_valid", 32'(s_if.data_valid), 32'd0);
        check("t4_gap_ctrl",  32'(ctrl), 32'd47);
        tick();
        check("t4_valid2", 32'(s_if.data_valid), 32'd1);
        check("t4_data2",  32'(s_if.data), 32'hC5);
        tick();
        check("t4_done", 32'(done), 32'd1);
        tick();

        // 5: full sweep, in[k] = k[0]; stray starts must be ignored
        for (int k = 0; k < 128; k++) in_vec[k] = k[0];
        start_scan(7'd0, 8'd0);
        first_ch = 7'd50;
        num_ch = 8'd4;
        nbytes = 0;
        done_edge = -1;
        for (int e = 1; e <= 200; e++) begin
            tick();
            if (s_if.data_valid) begin
                nbytes++;
                check("t5_byte", 32'(s_if.data), 32'hAA);
            end
            if (e == 21) check("t5_ctrl_ignore", 32'(ctrl), 32'd21);
            if (done) done_edge = e;
            start = (e == 20) || (e == 128) || (e == 129);
            if (done) break;
        end
        tick();
        start = 1'b0;
        check("t5_nbytes", 32'(nbytes), 32'd16);
        check("t5_done_edge", 32'(done_edge), 32'd129);
        check("t5_done_start_ign", 32'(busy), 32'd0);
        tick();
        check("t5_idle", 32'(busy), 32'd0);

        // 6: reset mid-scan, then a clean partial scan
        in_vec = '0;
        in_vec[15:0] = '1;
        start_scan(7'd0, 8'd16);
        repeat (5) tick();
        check("t6_ctrl5", 32'(ctrl), 32'd5);
        rst_n = 1'b0;
        tick();
        check("t6_busy",  32'(busy), 32'd0);
        check("t6_valid", 32'(s_if.data_valid), 32'd0);
        check("t6_done",  32'(done), 32'd0);
        check("t6_ctrl",  32'(ctrl), 32'd0);
        check("t6_data",  32'(s_if.data), 32'd0);
        rst_n = 1'b1;
        tick();
        check("t6_idle", 32'(busy), 32'd0);
        in_vec = '0;
        in_vec[1] = 1'b1;
        in_vec[4:3] = '1;
        start_scan(7'd0, 8'd3);
        repeat (3) tick();
        check("t6_valid2", 32'(s_if.data_valid), 32'd1);
        check("t6_data2",  32'(s_if.data), 32'h02);
        wait_done("t6_done2", 4);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
